// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, picks next-PC and aligns the one-cycle-latent IMEM data with it.
// Optional misaligned-redirect check is compiled in with `define IF_MISALIGN_CHK_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        fetch_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;

  // if_valid is a valid-only qualifier (no ready): the IF/ID register takes
  // if_pc/if_instr whenever if_valid=1, and the hazard unit back-pressures
  // through pc_stall, which holds all three outputs stable.

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_evt;
  logic err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if_valid  = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    misalign_evt = 1'b0;
`endif
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        // The word at pc is wrong-path whenever a redirect lands this cycle.
        if_valid = !br_taken;
        if (br_taken) begin
`ifdef IF_MISALIGN_CHK_EN
          if (br_target[1:0] != 2'b00) begin
            state_nxt    = HALT;
            misalign_evt = 1'b1;
          end else begin
            pc_nxt = br_target;
          end
`else
          pc_nxt = br_target & 32'hFFFF_FFFC;
`endif
        end else if (!pc_stall) begin
          pc_nxt = pc + 32'd4;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  // IMEM is addressed with the next PC so its registered output matches pc.
  assign imem_addr = pc_nxt[15:0];
  assign if_pc     = pc;
  assign if_instr  = if_valid ? imem_rdata : NOP_INSTR;
  assign state_dbg = state;

`ifdef IF_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | misalign_evt;
  end
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: reset, sequential fetch, stall, redirect, misaligned target, async reset.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        fetch_err;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0]  ST_BOOT = 2'd0;
  localparam logic [1:0]  ST_RUN  = 2'd1;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .pc_stall   (pc_stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_valid   (if_valid),
    .fetch_err  (fetch_err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // IMEM contents: two real instructions at 0/4, a tagged pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [15:0] addr);
    if (addr == 16'h0000)      return 32'h0010_0093;
    else if (addr == 16'h0004) return 32'h0020_0113;
    else                       return 32'hA500_0000 | {16'h0000, addr};
  endfunction

  // synchronous-read IMEM model
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // driver: advance to just after the next rising edge and set inputs
  task automatic cycle(input logic stall, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    pc_stall  = stall;
    br_taken  = br;
    br_target = tgt;
    @(negedge clk);
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc);
    check({tag, "_pc"},    if_pc, pc);
    check({tag, "_instr"}, if_instr, mem_word(pc[15:0]));
    check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
  endtask

  task automatic release_and_boot(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_boot_valid"}, {31'd0, if_valid}, 32'd0);
    check({tag, "_boot_state"}, {30'd0, state_dbg}, {30'd0, ST_BOOT});
    cycle(1'b0, 1'b0, 32'h0);
    expect_fetch({tag, "_c2"}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    expect_fetch({tag, "_c3"}, 32'h4);
  endtask

  initial begin
    rst       = 1'b1;
    pc_stall  = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, NOP);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_err",   {31'd0, fetch_err}, 32'd0);
    check("rst_addr",  {16'd0, imem_addr}, 32'h0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_BOOT});

    // reset release and sequential run 0..28
    release_and_boot("s1");
    check("s1_state", {30'd0, state_dbg}, {30'd0, ST_RUN});
    for (int i = 2; i < 8; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      expect_fetch($sformatf("seq%0d", i), 32'(i * 4));
      check($sformatf("seq%0d_addr", i), {16'd0, imem_addr}, 32'(i * 4 + 4));
    end

    // async reset while if_pc = 0x20
    cycle(1'b0, 1'b0, 32'h0);
    check("pre_rst_pc", if_pc, 32'h20);
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, if_valid}, 32'd0);
    check("arst_pc",    if_pc, 32'h0);
    check("arst_instr", if_instr, NOP);
    check("arst_addr",  {16'd0, imem_addr}, 32'h0);
    release_and_boot("s2");

    // stall three cycles at pc = 8
    cycle(1'b1, 1'b0, 32'h0);
    expect_fetch("stall0", 32'h8);
    cycle(1'b1, 1'b0, 32'h0);
    expect_fetch("stall1", 32'h8);
    check("stall1_addr", {16'd0, imem_addr}, 32'h8);
    cycle(1'b1, 1'b0, 32'h0);
    expect_fetch("stall2", 32'h8);
    cycle(1'b0, 1'b0, 32'h0);
    expect_fetch("unstall", 32'h8);
    cycle(1'b0, 1'b0, 32'h0);
    expect_fetch("post_stall", 32'hC);

    // redirect wins over stall at pc = 12
    br_taken  = 1'b1;
    br_target = 32'h40;
    pc_stall  = 1'b1;
    #1;
    check("br_valid", {31'd0, if_valid}, 32'd0);
    check("br_instr", if_instr, NOP);
    check("br_addr",  {16'd0, imem_addr}, 32'h40);
    cycle(1'b0, 1'b0, 32'h0);
    expect_fetch("br_tgt", 32'h40);

    // misaligned redirect target from pc = 0x40
    br_taken  = 1'b1;
    br_target = 32'h42;
    #1;
    check("mis_valid", {31'd0, if_valid}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
    check("mis_err",   {31'd0, fetch_err}, 32'd1);
    check("mis_valid1", {31'd0, if_valid}, 32'd0);
    check("mis_instr", if_instr, NOP);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      check($sformatf("halt%0d_valid", i), {31'd0, if_valid}, 32'd0);
      check($sformatf("halt%0d_err", i), {31'd0, fetch_err}, 32'd1);
    end
`else
    expect_fetch("mis_tgt", 32'h40);
    check("mis_err", {31'd0, fetch_err}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    expect_fetch("mis_next", 32'h44);
`endif

    // reset recovers from any state
    #1;
    rst = 1'b1;
    #1;
    check("rst3_err", {31'd0, fetch_err}, 32'd0);
    release_and_boot("s3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RV32 5-stage pipeline, sitting directly upstream of the synchronous-read instruction memory. It owns the program counter, selects next-PC (sequential, branch/jump redirect, or stall-hold), and drives the IMEM byte address. It aligns the one-cycle-latent IMEM read data with its PC and presents a valid instruction/PC pair to the IF/ID register.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned
- NOP_INSTR, 32'h0000_0013, instruction driven on `if_instr` when `if_valid`=0
- clk  input  1  pipeline clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- pc_stall  input  1  hazard unit: hold PC and presented instruction
- br_taken  input  1  EX stage: redirect fetch this cycle
- br_target  input  32  redirect byte address, valid when `br_taken`=1
- imem_addr  output  16  IMEM byte address; equals `pc_nxt[15:0]`, combinational
- imem_rdata  input  32  IMEM read data, one cycle after `imem_addr`
- if_pc  output  32  PC of presented instruction (= `pc` register)
- if_instr  output  32  presented instruction
- if_valid  output  1  `if_pc`/`if_instr` hold a real, non-killed instruction
- fetch_err  output  1  sticky misaligned-target error; tied 0 when check is compiled out

## Operation
- Registers: `pc` (32b) and `state` (BOOT, RUN, HALT).
- `imem_addr` = `pc_nxt[15:0]`. IMEM is read at the next PC, so `imem_rdata` in any cycle is the word at the current `pc`.
- BOOT: entered on reset. `pc_nxt` = `pc`. Primes the IMEM with `RESET_PC`. `if_valid`=0. Unconditionally goes to RUN after one clock; `br_taken` and `pc_stall` are ignored.
- RUN, `pc_nxt` priority:
  - `br_taken` → `br_target`
  - else `pc_stall` → `pc`
  - else `pc`+4
- RUN outputs:
  - `if_valid` = !`br_taken`; the instruction at `pc` is wrong-path when a redirect occurs.
  - `if_instr` = `imem_rdata` when `if_valid`=1, else `NOP_INSTR`.
- HALT: `pc_nxt` = `pc`, `if_valid`=0, `if_instr`=`NOP_INSTR`. Exits only by reset.
- Arithmetic: `pc`+4 wraps modulo 2^32. `imem_addr` truncates to 16 bits, so fetch aliases every 64 KiB.
- Stall with the IMEM: address is held, so the IMEM re-reads the same word and the presented instruction stays stable with no hold buffer.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `state`=BOOT
  - `if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc`=`RESET_PC`
  - `fetch_err`=0, `imem_addr`=`RESET_PC[15:0]`
- First valid instruction (`RESET_PC`) is presented in the 2nd cycle after `rst` deasserts (BOOT lasts one cycle).
- Redirect asserted in cycle N:
  - cycle N has `if_valid`=0
  - cycle N+1 presents `br_target` with `if_valid`=1 (zero-bubble beyond the killed slot)
- Stall in cycle N: `pc`, `if_pc`, `if_instr`, `if_valid` unchanged in N+1. Back-to-back stalls hold indefinitely.
- `br_taken` and `pc_stall` in the same cycle: redirect wins and the stall is ignored.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous); no in-flight instruction survives.

## Configuration
- `IF_MISALIGN_CHK_EN` defined:
  - `br_taken` with `br_target[1:0]`≠0 in RUN moves the state to HALT; `pc` is not updated.
  - `fetch_err` rises the next cycle and stays 1 until reset.
  - `if_valid`=0 from the offending cycle onward.
- Not defined:
  - `br_target[1:0]` is forced to 2'b00 and fetch continues normally.
  - No HALT entry; `fetch_err` is constant 0.

## Test plan
- Reset release with IMEM word0=32'h0010_0093, word1=32'h0020_0113 → cycle 1 `if_valid`=0; cycle 2 `if_pc`=0/`if_instr`=32'h0010_0093; cycle 3 `if_pc`=4/`if_instr`=32'h0020_0113.
- Sequential run of 8 cycles → `if_pc` steps 0,4,…,28; `imem_addr` always leads `if_pc` by 4.
- `pc_stall`=1 for 3 cycles at `if_pc`=8 → `if_pc`=8, same `if_instr`, `if_valid`=1 held for 3 cycles; `if_pc`=12 on release.
- `br_taken`=1 with `br_target`=32'h40 and `pc_stall`=1 at `if_pc`=12 → that cycle `if_valid`=0/`if_instr`=32'h13; next cycle `if_pc`=32'h40 with `if_valid`=1.
- `br_target`=32'h42 with macro defined → next cycle `fetch_err`=1, `if_valid`=0 permanently until `rst`. Without macro → `if_pc`=32'h40, `fetch_err`=0.
- `rst` pulsed while `if_pc`=32'h20 → same cycle `if_valid`=0 and `if_pc`=`RESET_PC`; resumes as in scenario 1.
